// File: rtl/alu_seq_pkg.sv
// Shared definitions for the alu_seq issue/writeback sequencer: ALU opcodes,
// FSM state encoding and default geometry.
package alu_seq_pkg;

  localparam int DW_DEF   = 8;
  localparam int NREG_DEF = 8;

  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_SUB  = 3'b001;
  localparam logic [2:0] OP_AND  = 3'b010;
  localparam logic [2:0] OP_OR   = 3'b011;
  localparam logic [2:0] OP_XOR  = 3'b100;
  localparam logic [2:0] OP_GT   = 3'b101;
  localparam logic [2:0] OP_SHLA = 3'b110;
  localparam logic [2:0] OP_SHLB = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/alu_seq_if.sv
// Host-side bundle of alu_seq: instruction and register-load handshakes,
// result strobe and architectural flags. slave = sequencer, master = host.
interface alu_seq_if #(
  parameter int DW = 8,
  parameter int AW = 3
);
  logic          in_valid;
  logic          in_ready;
  logic [2:0]    in_op;
  logic [AW-1:0] in_dst;
  logic [AW-1:0] in_src_a;
  logic [AW-1:0] in_src_b;
  logic          in_cin;

  logic          ld_valid;
  logic          ld_ready;
  logic [AW-1:0] ld_addr;
  logic [DW-1:0] ld_data;

  logic          res_valid;
  logic [DW-1:0] res_data;
  logic [AW-1:0] res_dst;
  logic          carry_flag;
  logic          zero_flag;

  modport slave (
    input  in_valid, in_op, in_dst, in_src_a, in_src_b, in_cin,
    input  ld_valid, ld_addr, ld_data,
    output in_ready, ld_ready,
    output res_valid, res_data, res_dst, carry_flag, zero_flag
  );

  modport master (
    output in_valid, in_op, in_dst, in_src_a, in_src_b, in_cin,
    output ld_valid, ld_addr, ld_data,
    input  in_ready, ld_ready,
    input  res_valid, res_data, res_dst, carry_flag, zero_flag
  );
endinterface

// File: rtl/alu_seq_regfile.sv
// NREG x DW register file, two combinational read ports, one write port.
// Write lands on the next rising edge; synchronous reset clears every entry.
module alu_seq_regfile
  import alu_seq_pkg::*;
#(
  parameter int DW   = DW_DEF,
  parameter int NREG = NREG_DEF,
  localparam int AW  = $clog2(NREG)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [AW-1:0] ra_addr,
  output logic [DW-1:0] ra_data,
  input  logic [AW-1:0] rb_addr,
  output logic [DW-1:0] rb_data,
  input  logic          we,
  input  logic [AW-1:0] wa,
  input  logic [DW-1:0] wd
);

  logic [DW-1:0] rf [NREG];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) rf[i] <= '0;
    end else if (we) begin
      rf[wa] <= wd;
    end
  end

  assign ra_data = rf[ra_addr];
  assign rb_data = rf[rb_addr];

endmodule

// File: rtl/alu_seq.sv
// Issue/writeback sequencer around an external 8-bit ALU (ALU_SEQ_CARRY_CHAIN_EN feeds carry_flag to cin).
// Latency accept->res_valid 2 cycles, one instruction per 3; loads beat instructions, no result backpressure.
module alu_seq
  import alu_seq_pkg::*;
#(
  parameter int DW   = DW_DEF,
  parameter int NREG = NREG_DEF,
  localparam int AW  = $clog2(NREG)
) (
  input  logic          clk,
  input  logic          rst,
  alu_seq_if.slave      bus,
  output logic [DW-1:0] alu_a,
  output logic [DW-1:0] alu_b,
  output logic [2:0]    alu_opcode,
  output logic          alu_cin,
  input  logic [DW-1:0] alu_out,
  input  logic          alu_cout,
  input  logic          alu_cflag,
  input  logic          alu_zflag
);

  state_t        state, state_nxt;

  logic [DW-1:0] opa_q, opb_q;
  logic [2:0]    op_q;
  logic [AW-1:0] dst_q;
  logic          cin_q;

  logic [DW-1:0] res_data_q;
  logic [AW-1:0] res_dst_q;
  logic          carry_q, zero_q;

  logic          in_rdy, ld_rdy, res_vld;
  logic          accept, ld_fire, exec;
  logic          rf_we;
  logic [AW-1:0] rf_wa;
  logic [DW-1:0] rf_wd;
  logic [DW-1:0] rd_a, rd_b;

  alu_seq_regfile #(.DW(DW), .NREG(NREG)) u_rf (
    .clk     (clk),
    .rst     (rst),
    .ra_addr (bus.in_src_a),
    .ra_data (rd_a),
    .rb_addr (bus.in_src_b),
    .rb_data (rd_b),
    .we      (rf_we),
    .wa      (rf_wa),
    .wd      (rf_wd)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (accept) state_nxt = ST_EXEC;
      ST_EXEC: state_nxt = ST_DONE;
      ST_DONE: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Host load and writeback share the single write port; they never coincide
  // because loads are only taken in IDLE and writeback only happens in EXEC.
  always_comb begin
    ld_rdy  = (state == ST_IDLE);
    in_rdy  = (state == ST_IDLE) && !bus.ld_valid;
    res_vld = (state == ST_DONE);
    exec    = (state == ST_EXEC);
    ld_fire = ld_rdy && bus.ld_valid;
    accept  = in_rdy && bus.in_valid;
    rf_we   = ld_fire || exec;
    rf_wa   = exec ? dst_q   : bus.ld_addr;
    rf_wd   = exec ? alu_out : bus.ld_data;
  end

  // Operands are captured at accept, so dst aliasing a source is harmless.
  always_ff @(posedge clk) begin
    if (rst) begin
      opa_q <= '0;
      opb_q <= '0;
      op_q  <= '0;
      dst_q <= '0;
      cin_q <= 1'b0;
    end else if (accept) begin
      opa_q <= rd_a;
      opb_q <= rd_b;
      op_q  <= bus.in_op;
      dst_q <= bus.in_dst;
`ifdef ALU_SEQ_CARRY_CHAIN_EN
      cin_q <= carry_q;
`else
      cin_q <= bus.in_cin;
`endif
    end
  end

  // Operand registers only change on accept, so they hold outside EXEC.
  assign alu_a      = opa_q;
  assign alu_b      = opb_q;
  assign alu_opcode = op_q;
  assign alu_cin    = cin_q;

  // cout/cflag are only meaningful for add/sub and compare respectively.
  always_ff @(posedge clk) begin
    if (rst) begin
      res_data_q <= '0;
      res_dst_q  <= '0;
      carry_q    <= 1'b0;
      zero_q     <= 1'b0;
    end else if (exec) begin
      res_data_q <= alu_out;
      res_dst_q  <= dst_q;
      zero_q     <= alu_zflag;
      if (op_q == OP_ADD || op_q == OP_SUB) carry_q <= alu_cout;
      else if (op_q == OP_GT)               carry_q <= alu_cflag;
    end
  end

  assign bus.in_ready   = in_rdy;
  assign bus.ld_ready   = ld_rdy;
  assign bus.res_valid  = res_vld;
  assign bus.res_data   = res_data_q;
  assign bus.res_dst    = res_dst_q;
  assign bus.carry_flag = carry_q;
  assign bus.zero_flag  = zero_q;

endmodule

// File: tb/tb_alu_seq.sv
// Bench for alu_seq: behavioural ALU stub plus an architectural reference
// model (register array and flags) driven by directed and random steps.
module tb_alu_seq;
  import alu_seq_pkg::*;

`ifdef ALU_SEQ_CARRY_CHAIN_EN
  localparam bit CHAIN = 1'b1;
`else
  localparam bit CHAIN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  alu_seq_if #(.DW(8), .AW(3)) bus ();

  logic [7:0] alu_a, alu_b, alu_out;
  logic [2:0] alu_opcode;
  logic       alu_cin, alu_cout, alu_cflag, alu_zflag;

  alu_seq #(.DW(8), .NREG(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_opcode (alu_opcode),
    .alu_cin    (alu_cin),
    .alu_out    (alu_out),
    .alu_cout   (alu_cout),
    .alu_cflag  (alu_cflag),
    .alu_zflag  (alu_zflag)
  );

  typedef struct packed {
    logic [7:0] out;
    logic       cout;
    logic       cflag;
  } ares_t;

  function automatic ares_t alu_f(input logic [2:0] op, input logic [7:0] a,
                                  input logic [7:0] b, input logic cin);
    ares_t r;
    int    s;
    r = '0;
    case (op)
      OP_ADD: begin
        s = int'(a) + int'(b) + int'(cin);
        r.out  = 8'(s);
        r.cout = (s > 255);
      end
      OP_SUB: begin
        r.out  = 8'(int'(a) - int'(b));
        r.cout = (a >= b);
      end
      OP_AND:  r.out = a & b;
      OP_OR:   r.out = a | b;
      OP_XOR:  r.out = a ^ b;
      OP_GT: begin
        r.cflag = (a > b);
        r.out   = (a > b) ? 8'd1 : 8'd0;
      end
      OP_SHLA: r.out = 8'(int'(a) * 2);
      default: r.out = 8'(int'(b) * 2);
    endcase
    return r;
  endfunction

  // ALU stub: cout/cflag carry random junk whenever they are not defined.
  logic [1:0] junk;
  ares_t      stub_r;
  always @(posedge clk) junk <= 2'($urandom);
  always_comb begin
    stub_r    = alu_f(alu_opcode, alu_a, alu_b, alu_cin);
    alu_out   = stub_r.out;
    alu_zflag = (stub_r.out == 8'd0);
    alu_cout  = (alu_opcode == OP_ADD || alu_opcode == OP_SUB) ? stub_r.cout : junk[0];
    alu_cflag = (alu_opcode == OP_GT) ? stub_r.cflag : junk[1];
  end

  logic [7:0] rf_m [8];
  logic       carry_m, zero_m;
  logic [7:0] obs_data;
  int         tests  = 0;
  int         failed = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_model();
    for (int i = 0; i < 8; i++) rf_m[i] = 8'd0;
    carry_m = 1'b0;
    zero_m  = 1'b0;
  endtask

  // All tasks start and end at a falling edge.
  task automatic load(input logic [2:0] addr, input logic [7:0] data);
    bus.ld_valid = 1'b1;
    bus.ld_addr  = addr;
    bus.ld_data  = data;
    #1;
    check("ld_ready", 32'(bus.ld_ready), 32'd1);
    @(posedge clk);
    @(negedge clk);
    bus.ld_valid = 1'b0;
    rf_m[addr]   = data;
  endtask

  task automatic start(input logic [2:0] op, input logic [2:0] dst, input logic [2:0] sa,
                       input logic [2:0] sb, input logic cin);
    bus.in_valid = 1'b1;
    bus.in_op    = op;
    bus.in_dst   = dst;
    bus.in_src_a = sa;
    bus.in_src_b = sb;
    bus.in_cin   = cin;
  endtask

  task automatic run(input logic [2:0] op, input logic [2:0] dst, input logic [2:0] sa,
                     input logic [2:0] sb, input logic cin);
    logic [7:0] ea, eb;
    logic       ecin;
    ares_t      r;
    #1;
    check("in_ready_idle", 32'(bus.in_ready), 32'd1);
    ea   = rf_m[sa];
    eb   = rf_m[sb];
    ecin = CHAIN ? carry_m : cin;
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    check("exec_alu_a", 32'(alu_a), 32'(ea));
    check("exec_alu_b", 32'(alu_b), 32'(eb));
    check("exec_opcode", 32'(alu_opcode), 32'(op));
    check("exec_cin", 32'(alu_cin), 32'(ecin));
    check("exec_res_valid", 32'(bus.res_valid), 32'd0);
    check("exec_in_ready", 32'(bus.in_ready), 32'd0);
    r        = alu_f(op, ea, eb, ecin);
    rf_m[dst] = r.out;
    zero_m   = (r.out == 8'd0);
    if (op == OP_ADD || op == OP_SUB) carry_m = r.cout;
    else if (op == OP_GT)             carry_m = r.cflag;
    @(negedge clk);
    check("done_res_valid", 32'(bus.res_valid), 32'd1);
    check("done_res_data", 32'(bus.res_data), 32'(r.out));
    check("done_res_dst", 32'(bus.res_dst), 32'(dst));
    check("done_carry", 32'(bus.carry_flag), 32'(carry_m));
    check("done_zero", 32'(bus.zero_flag), 32'(zero_m));
    check("done_in_ready", 32'(bus.in_ready), 32'd0);
    check("done_ld_ready", 32'(bus.ld_ready), 32'd0);
    obs_data = bus.res_data;
    @(negedge clk);
    check("idle_res_valid", 32'(bus.res_valid), 32'd0);
  endtask

  task automatic issue(input logic [2:0] op, input logic [2:0] dst, input logic [2:0] sa,
                       input logic [2:0] sb, input logic cin);
    start(op, dst, sa, sb, cin);
    run(op, dst, sa, sb, cin);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout tests=%0d failed=%0d", tests, failed);
    $fatal(1, "watchdog");
  end

  initial begin
    rst          = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_op    = 3'd0;
    bus.in_dst   = 3'd0;
    bus.in_src_a = 3'd0;
    bus.in_src_b = 3'd0;
    bus.in_cin   = 1'b0;
    bus.ld_valid = 1'b0;
    bus.ld_addr  = 3'd0;
    bus.ld_data  = 8'd0;
    clear_model();
    repeat (3) @(negedge clk);

    check("rst_alu_a", 32'(alu_a), 32'd0);
    check("rst_alu_b", 32'(alu_b), 32'd0);
    check("rst_opcode", 32'(alu_opcode), 32'd0);
    check("rst_cin", 32'(alu_cin), 32'd0);
    check("rst_res_valid", 32'(bus.res_valid), 32'd0);
    check("rst_res_data", 32'(bus.res_data), 32'd0);
    check("rst_res_dst", 32'(bus.res_dst), 32'd0);
    check("rst_carry", 32'(bus.carry_flag), 32'd0);
    check("rst_zero", 32'(bus.zero_flag), 32'd0);
    rst = 1'b0;
    #1;
    check("post_rst_in_ready", 32'(bus.in_ready), 32'd1);
    check("post_rst_ld_ready", 32'(bus.ld_ready), 32'd1);
    @(negedge clk);

    load(3'd1, 8'h05);
    load(3'd2, 8'h03);
    issue(OP_ADD, 3'd3, 3'd1, 3'd2, 1'b0);
    check("add_data", 32'(obs_data), 32'h08);
    check("add_carry", 32'(bus.carry_flag), 32'd0);
    check("add_zero", 32'(bus.zero_flag), 32'd0);

    issue(OP_SUB, 3'd4, 3'd1, 3'd2, 1'b0);
    check("sub_data", 32'(obs_data), 32'h02);
    check("sub_carry", 32'(bus.carry_flag), 32'd1);
    issue(OP_SUB, 3'd4, 3'd2, 3'd1, 1'b0);
    check("sub_borrow_data", 32'(obs_data), 32'hFE);
    check("sub_borrow_carry", 32'(bus.carry_flag), 32'd0);

    load(3'd5, 8'hFF);
    load(3'd6, 8'h01);
    issue(OP_ADD, 3'd7, 3'd5, 3'd6, 1'b0);
    check("wrap_data", 32'(obs_data), 32'h00);
    check("wrap_carry", 32'(bus.carry_flag), 32'd1);
    check("wrap_zero", 32'(bus.zero_flag), 32'd1);
    issue(OP_ADD, 3'd0, 3'd0, 3'd0, 1'b0);
    check("chain_data", 32'(obs_data), CHAIN ? 32'h01 : 32'h00);

    issue(OP_GT, 3'd3, 3'd2, 3'd1, 1'b0);
    check("gt_data", 32'(obs_data), 32'h00);
    check("gt_carry", 32'(bus.carry_flag), 32'd0);
    check("gt_zero", 32'(bus.zero_flag), 32'd1);
    issue(OP_XOR, 3'd4, 3'd1, 3'd2, 1'b0);
    check("xor_data", 32'(obs_data), 32'h06);
    check("xor_carry_kept", 32'(bus.carry_flag), 32'd0);

    // Reset while the instruction is in EXEC must kill its result.
    start(OP_ADD, 3'd3, 3'd1, 3'd2, 1'b0);
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    rst = 1'b1;
    check("abort_exec_res_valid", 32'(bus.res_valid), 32'd0);
    @(negedge clk);
    check("abort_res_valid", 32'(bus.res_valid), 32'd0);
    rst = 1'b0;
    clear_model();
    #1;
    check("abort_in_ready", 32'(bus.in_ready), 32'd1);
    check("abort_res_data", 32'(bus.res_data), 32'd0);
    check("abort_alu_a", 32'(alu_a), 32'd0);
    @(negedge clk);
    check("abort_no_strobe", 32'(bus.res_valid), 32'd0);
    issue(OP_ADD, 3'd3, 3'd1, 3'd2, 1'b0);
    check("abort_rf_cleared", 32'(obs_data), 32'h00);

    // Load and instruction in the same IDLE cycle: load first.
    bus.ld_valid = 1'b1;
    bus.ld_addr  = 3'd1;
    bus.ld_data  = 8'h10;
    start(OP_ADD, 3'd7, 3'd1, 3'd1, 1'b0);
    #1;
    check("coll_in_ready", 32'(bus.in_ready), 32'd0);
    check("coll_ld_ready", 32'(bus.ld_ready), 32'd1);
    @(posedge clk);
    @(negedge clk);
    bus.ld_valid = 1'b0;
    rf_m[1]      = 8'h10;
    run(OP_ADD, 3'd7, 3'd1, 3'd1, 1'b0);
    check("coll_data", 32'(obs_data), 32'h20);

    for (int i = 0; i < 80; i++) begin
      if ($urandom_range(0, 3) == 0)
        load(3'($urandom), 8'($urandom));
      else
        issue(3'($urandom), 3'($urandom), 3'($urandom), 3'($urandom), 1'($urandom));
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
